// File: rtl/axis_flit_injector.sv
// rtl/axis_flit_injector.sv - AXI-Stream beat to NoC flit serializer with credit-based flow control
// Define AXIS_INJ_STATS_EN to add the pkt_count / stall_count statistics outputs.
module axis_flit_injector #(
    parameter int TDATA_WIDTH          = 32,
    parameter int DEST_WIDTH           = 4,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int FLIT_BUFFER_DEPTH    = 2,
    localparam int FLIT_WIDTH          = TDATA_WIDTH / SERIALIZATION_FACTOR
) (
    input  logic                   clk_noc,
    input  logic                   rst_noc,
    input  logic                   axis_tvalid,
    output logic                   axis_tready,
    input  logic [TDATA_WIDTH-1:0] axis_tdata,
    input  logic                   axis_tlast,
    input  logic [DEST_WIDTH-1:0]  axis_tdest,
    output logic [FLIT_WIDTH-1:0]  data_out,
    output logic [DEST_WIDTH-1:0]  dest_out,
    output logic                   is_tail_out,
    output logic                   send_out,
    input  logic                   credit_in,
    output logic                   credit_err
`ifdef AXIS_INJ_STATS_EN
    ,
    output logic [31:0]            pkt_count,
    output logic [31:0]            stall_count
`endif
);

    localparam int IDX_W = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam int CRD_W = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SERIALIZATION_FACTOR - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TDATA_WIDTH-1:0] hold_q, hold_d;
    logic                   beat_tail_q, beat_tail_d;
    logic                   head_q, head_d;
    logic [DEST_WIDTH-1:0]  pkt_dest_q, pkt_dest_d;
    logic [CRD_W-1:0]       credit_q, credit_d;
    logic                   err_q, err_d;
    logic [FLIT_WIDTH-1:0]  data_q, data_d;
    logic [DEST_WIDTH-1:0]  dest_q, dest_d;
    logic                   tail_q, tail_d;
    logic                   send_q;

    logic                   issue;
    logic                   last_slice;
    logic                   accept;
    logic [FLIT_WIDTH-1:0]  slice;

    assign issue       = (state_q == SEND) && (credit_q != '0);
    assign last_slice  = (idx_q == IDX_LAST);
    assign axis_tready = !rst_noc && ((state_q == IDLE) || (issue && last_slice));
    assign accept      = axis_tvalid && axis_tready;

    always_comb begin
        slice = hold_q[FLIT_WIDTH-1:0];
        for (int i = 1; i < SERIALIZATION_FACTOR; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice = hold_q[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        beat_tail_d = beat_tail_q;
        head_d      = head_q;
        pkt_dest_d  = pkt_dest_q;
        data_d      = data_q;
        dest_d      = dest_q;
        tail_d      = tail_q;
        credit_d    = credit_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (issue) begin
                    if (last_slice) begin
                        idx_d   = '0;
                        state_d = accept ? SEND : IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Destination is only sampled on the head beat; later beats inherit it.
        if (accept) begin
            hold_d      = axis_tdata;
            beat_tail_d = axis_tlast;
            head_d      = axis_tlast;
            if (head_q) begin
                pkt_dest_d = axis_tdest;
            end
        end

        if (issue) begin
            data_d = slice;
            dest_d = pkt_dest_q;
            tail_d = beat_tail_q && last_slice;
        end

        if (issue && !credit_in) begin
            credit_d = credit_q - 1'b1;
        end else if (credit_in && !issue) begin
            if (credit_q == CRD_MAX) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            beat_tail_q <= 1'b0;
            head_q      <= 1'b1;
            pkt_dest_q  <= '0;
            credit_q    <= CRD_MAX;
            err_q       <= 1'b0;
            data_q      <= '0;
            dest_q      <= '0;
            tail_q      <= 1'b0;
            send_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            beat_tail_q <= beat_tail_d;
            head_q      <= head_d;
            pkt_dest_q  <= pkt_dest_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
            data_q      <= data_d;
            dest_q      <= dest_d;
            tail_q      <= tail_d;
            send_q      <= issue;
        end
    end

    assign data_out    = data_q;
    assign dest_out    = dest_q;
    assign is_tail_out = tail_q;
    assign send_out    = send_q;
    assign credit_err  = err_q;

`ifdef AXIS_INJ_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue && last_slice && beat_tail_q) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if ((state_q == SEND) && (credit_q == '0)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign pkt_count   = pkt_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axis_flit_injector.sv
// tb/tb_axis_flit_injector.sv - directed bench for axis_flit_injector (SF=4/2/1 instances)
module tb_axis_flit_injector;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // a_*: SF=4 depth 8, b_*: SF=2 depth 2, c_*: SF=1 depth 2
    logic        a_vld, a_rdy, a_last, a_tail, a_send, a_crd, a_err;
    logic [31:0] a_tdata;
    logic [3:0]  a_tdest, a_dest;
    logic [7:0]  a_data;
    logic        b_vld, b_rdy, b_last, b_tail, b_send, b_crd, b_err;
    logic [31:0] b_tdata;
    logic [3:0]  b_tdest, b_dest;
    logic [15:0] b_data;
    logic        c_vld, c_rdy, c_last, c_tail, c_send, c_crd, c_err;
    logic [31:0] c_tdata;
    logic [3:0]  c_tdest, c_dest;
    logic [31:0] c_data;
`ifdef AXIS_INJ_STATS_EN
    logic [31:0] a_pkt, a_stall, b_pkt, b_stall, c_pkt, c_stall;
`endif

    axis_flit_injector #(.TDATA_WIDTH(32), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(8)) u_a (
        .clk_noc(clk), .rst_noc(rst), .axis_tvalid(a_vld), .axis_tready(a_rdy), .axis_tdata(a_tdata),
        .axis_tlast(a_last), .axis_tdest(a_tdest), .data_out(a_data), .dest_out(a_dest),
        .is_tail_out(a_tail), .send_out(a_send), .credit_in(a_crd), .credit_err(a_err)
`ifdef AXIS_INJ_STATS_EN
        , .pkt_count(a_pkt), .stall_count(a_stall)
`endif
    );

    axis_flit_injector #(.TDATA_WIDTH(32), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(2), .FLIT_BUFFER_DEPTH(2)) u_b (
        .clk_noc(clk), .rst_noc(rst), .axis_tvalid(b_vld), .axis_tready(b_rdy), .axis_tdata(b_tdata),
        .axis_tlast(b_last), .axis_tdest(b_tdest), .data_out(b_data), .dest_out(b_dest),
        .is_tail_out(b_tail), .send_out(b_send), .credit_in(b_crd), .credit_err(b_err)
`ifdef AXIS_INJ_STATS_EN
        , .pkt_count(b_pkt), .stall_count(b_stall)
`endif
    );

    axis_flit_injector #(.TDATA_WIDTH(32), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(2)) u_c (
        .clk_noc(clk), .rst_noc(rst), .axis_tvalid(c_vld), .axis_tready(c_rdy), .axis_tdata(c_tdata),
        .axis_tlast(c_last), .axis_tdest(c_tdest), .data_out(c_data), .dest_out(c_dest),
        .is_tail_out(c_tail), .send_out(c_send), .credit_in(c_crd), .credit_err(c_err)
`ifdef AXIS_INJ_STATS_EN
        , .pkt_count(c_pkt), .stall_count(c_stall)
`endif
    );

    typedef struct {
        logic        vld;
        logic [31:0] tdata;
        logic        last;
        logic [3:0]  tdest;
        logic        crd;
        logic        x_rdy;
        logic        x_send;
        logic [7:0]  x_data;
        logic [3:0]  x_dest;
        logic        x_tail;
    } vec_t;

    vec_t tbl [15];

    int b_flits = 0;
    always @(negedge clk) if (!rst && b_send) b_flits++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int cnt;
        rst = 1'b1;
        {a_vld, a_last, a_crd, b_vld, b_last, b_crd, c_vld, c_last, c_crd} = '0;
        a_tdata = '0; b_tdata = '0; c_tdata = '0;
        a_tdest = '0; b_tdest = '0; c_tdest = '0;

        tbl[0]  = '{1'b1, 32'hDDCCBBAA, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hAA, 4'h5, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hBB, 4'h5, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hCC, 4'h5, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'hDD, 4'h5, 1'b1};
        tbl[5]  = '{1'b1, 32'h44332211, 1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 8'hDD, 4'h5, 1'b1};
        tbl[6]  = '{1'b1, 32'h88776655, 1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 8'h11, 4'hA, 1'b0};
        tbl[7]  = '{1'b1, 32'h88776655, 1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 8'h22, 4'hA, 1'b0};
        tbl[8]  = '{1'b1, 32'h88776655, 1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 8'h33, 4'hA, 1'b0};
        tbl[9]  = '{1'b1, 32'h88776655, 1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 8'h44, 4'hA, 1'b0};
        tbl[10] = '{1'b0, 32'h0,        1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'h55, 4'hA, 1'b0};
        tbl[11] = '{1'b0, 32'h0,        1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'h66, 4'hA, 1'b0};
        tbl[12] = '{1'b0, 32'h0,        1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'h77, 4'hA, 1'b0};
        tbl[13] = '{1'b0, 32'h0,        1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 8'h88, 4'hA, 1'b1};
        tbl[14] = '{1'b0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h88, 4'hA, 1'b1};

        // Reset state
        #1;
        chk("rst_tready", a_rdy, 0);
        chk("rst_send", a_send, 0);
        chk("rst_data", a_data, 0);
        chk("rst_dest", a_dest, 0);
        chk("rst_tail", a_tail, 0);
        chk("rst_err", a_err, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("release_tready", a_rdy, 1);

        // SF=4 table: single beat, then a two-beat back-to-back packet
        for (int i = 0; i < 15; i++) begin
            a_vld = tbl[i].vld; a_tdata = tbl[i].tdata; a_last = tbl[i].last;
            a_tdest = tbl[i].tdest; a_crd = tbl[i].crd;
            #1;
            chk($sformatf("tbl%0d_tready", i), a_rdy, tbl[i].x_rdy);
            tick();
            chk($sformatf("tbl%0d_send", i), a_send, tbl[i].x_send);
            chk($sformatf("tbl%0d_data", i), a_data, tbl[i].x_data);
            chk($sformatf("tbl%0d_dest", i), a_dest, tbl[i].x_dest);
            chk($sformatf("tbl%0d_tail", i), a_tail, tbl[i].x_tail);
            chk($sformatf("tbl%0d_err", i), a_err, 0);
        end

        // SF=1: three beats back to back, destination from the head beat only
        c_vld = 1; c_tdata = 32'h1; c_tdest = 4'h3; c_last = 0; c_crd = 0;
        #1; chk("c0_tready", c_rdy, 1);
        tick(); chk("c0_send", c_send, 0);
        c_tdata = 32'h2; c_tdest = 4'h7; c_crd = 1;
        #1; chk("c1_tready", c_rdy, 1);
        tick(); chk("c1_send", c_send, 1); chk("c1_data", c_data, 32'h1); chk("c1_dest", c_dest, 4'h3); chk("c1_tail", c_tail, 0);
        c_tdata = 32'h3; c_tdest = 4'h9; c_last = 1;
        #1; chk("c2_tready", c_rdy, 1);
        tick(); chk("c2_send", c_send, 1); chk("c2_data", c_data, 32'h2); chk("c2_dest", c_dest, 4'h3); chk("c2_tail", c_tail, 0);
        c_vld = 0; c_last = 0;
        tick(); chk("c3_send", c_send, 1); chk("c3_data", c_data, 32'h3); chk("c3_dest", c_dest, 4'h3); chk("c3_tail", c_tail, 1);
        c_crd = 0;
        tick(); chk("c4_send", c_send, 0); chk("c4_err", c_err, 0);

        // SF=1: credit overflow at full count is sticky and does not wrap
        c_crd = 1;
        tick(); chk("ovf_err_set", c_err, 1);
        c_crd = 0;
        tick(); tick(); chk("ovf_err_sticky", c_err, 1);
        acc = 0; cnt = 0;
        for (int k = 0; k < 8; k++) begin
            c_vld = (acc < 3); c_last = 1; c_tdata = 32'h10 + acc;
            #1;
            if (c_vld && c_rdy) acc++;
            tick();
            if (c_send) cnt++;
        end
        c_vld = 0;
        chk("sat_flits", cnt, 2);
        chk("sat_err_still", c_err, 1);

        // SF=2 depth 2, no credits: 2 flits then stall, one flit per credit
        b_vld = 1; b_tdata = 32'h22221111; b_tdest = 4'h3; b_last = 0;
        #1; chk("b0_tready", b_rdy, 1);
        tick(); chk("b0_send", b_send, 0);
        b_tdata = 32'h44443333; b_tdest = 4'hE; b_last = 1;
        #1; chk("b1_tready", b_rdy, 0);
        tick(); chk("b1_send", b_send, 1); chk("b1_data", b_data, 16'h1111); chk("b1_dest", b_dest, 4'h3);
        #1; chk("b2_tready", b_rdy, 1);
        tick(); chk("b2_send", b_send, 1); chk("b2_data", b_data, 16'h2222);
        b_vld = 0; b_last = 0;
        for (int k = 0; k < 3; k++) begin
            #1; chk($sformatf("stall%0d_tready", k), b_rdy, 0);
            tick(); chk($sformatf("stall%0d_send", k), b_send, 0);
        end
        b_crd = 1; tick(); b_crd = 0; chk("cr1_nosend", b_send, 0);
        tick(); chk("cr1_send", b_send, 1); chk("cr1_data", b_data, 16'h3333); chk("cr1_dest", b_dest, 4'h3); chk("cr1_tail", b_tail, 0);
        tick(); chk("cr1_stall", b_send, 0);
        b_crd = 1; tick(); b_crd = 0;
        tick(); chk("cr2_send", b_send, 1); chk("cr2_data", b_data, 16'h4444); chk("cr2_tail", b_tail, 1);
        tick(); tick();
        chk("b_total_flits", b_flits, 4);

        // Reset clears sticky error
        rst = 1'b1; #1;
        chk("rst_clears_err", c_err, 0);
        tick(); rst = 1'b0; #1;

`ifdef AXIS_INJ_STATS_EN
        chk("stats_pkt_rst", b_pkt, 0);
        chk("stats_stall_rst", b_stall, 0);
        acc = 0;
        for (int k = 0; k < 14; k++) begin
            b_vld = (acc < 3); b_last = 1; b_tdata = 32'h00020001;
            b_crd = (k >= 7 && k <= 11);
            #1;
            if (b_vld && b_rdy) acc++;
            tick();
        end
        b_vld = 0; b_crd = 0;
        chk("stats_pkt", b_pkt, 3);
        chk("stats_stall", b_stall, 5);
`endif

        // SF=4: reset mid-packet after the first slice
        a_vld = 1; a_tdata = 32'h04030201; a_tdest = 4'h6; a_last = 1; a_crd = 0;
        tick(); a_vld = 0;
        tick(); chk("mid_send", a_send, 1); chk("mid_data", a_data, 8'h01);
        rst = 1'b1; #1;
        chk("mid_rst_send", a_send, 0);
        chk("mid_rst_data", a_data, 0);
        chk("mid_rst_dest", a_dest, 0);
        chk("mid_rst_tready", a_rdy, 0);
        tick(); rst = 1'b0; #1;
        chk("mid_rel_tready", a_rdy, 1);
        a_vld = 1; a_tdata = 32'hD4C3B2A1; a_tdest = 4'h9; a_last = 1;
        tick(); a_vld = 0;
        chk("new_nosend", a_send, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("new%0d_send", k), a_send, 1);
            chk($sformatf("new%0d_data", k), a_data, 8'hA1 + 8'h11 * k);
            chk($sformatf("new%0d_dest", k), a_dest, 4'h9);
            chk($sformatf("new%0d_tail", k), a_tail, (k == 3));
        end
        tick(); chk("new_end_send", a_send, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
